fetch_unit: RTL and testbench

- Instruction-fetch front end that produces the 32-bit DLX instruction word consumed by the control decoder.
- Owns the PC. Issues single-outstanding requests to instruction memory and presents each fetched word to decode through a valid/ready handshake.
- Applies control-flow redirects (beqz/bnez taken, j/jal, jr/jalr) for the most recently accepted instruction.
- Discards wrong-path words that are already held or in flight.

---
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// DLX instruction-fetch front end: owns the PC, issues one outstanding imem
// request at a time and hands each word to decode over a valid/ready pair.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_data,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target
);

  // state | meaning
  // FETCH | request outstanding at pc, waiting for imem_rdy
  // HOLD  | word held for decode, no request issued
  // DRAIN | wrong-path request still in flight; word dropped, then pc <= saved_target
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] saved_target, saved_target_nx;
  logic [25:0] last_off, last_off_nx;
  logic [31:0] last_pc, last_pc_nx;
  logic [31:0] inst_nx, inst_pc_nx;
  logic        redir;
  logic [31:0] seq_pc, jump_off, br_off, raw_target, target;

  assign imem_req  = !reset && (state != HOLD);
  assign imem_addr = pc;
  assign redir     = branch_taken | jump | jr;

  // Only the low 26 bits of the last accepted word feed any target.
  always_comb begin
    seq_pc   = last_pc + 32'd4;
    jump_off = {{6{last_off[25]}}, last_off};
    br_off   = {{16{last_off[15]}}, last_off[15:0]};
    if (jr)        raw_target = jr_target;
    else if (jump) raw_target = seq_pc + jump_off;
    else           raw_target = seq_pc + br_off;
    target = raw_target & ~32'h3;
  end

  always_comb begin
    state_nx        = state;
    pc_nx           = pc;
    saved_target_nx = saved_target;
    last_off_nx     = last_off;
    last_pc_nx      = last_pc;
    inst_nx         = inst;
    inst_pc_nx      = inst_pc;
    case (state)
      FETCH: begin
        if (redir) begin
          if (imem_rdy) begin
            pc_nx = target;
          end else begin
            saved_target_nx = target;
            state_nx        = DRAIN;
          end
        end else if (imem_rdy) begin
          inst_nx    = imem_data;
          inst_pc_nx = pc;
          state_nx   = HOLD;
        end
      end
      HOLD: begin
        // A redirect wins over a same-cycle acceptance of the held word.
        if (redir) begin
          pc_nx    = target;
          state_nx = FETCH;
        end else if (inst_ready) begin
          last_off_nx = inst[25:0];
          last_pc_nx  = inst_pc;
          pc_nx       = inst_pc + 32'd4;
          state_nx    = FETCH;
        end
      end
      DRAIN: begin
        if (imem_rdy) begin
          pc_nx    = saved_target;
          state_nx = FETCH;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      saved_target <= '0;
      last_off     <= '0;
      last_pc      <= '0;
      inst         <= '0;
      inst_pc      <= '0;
      inst_valid   <= 1'b0;
    end else begin
      state        <= state_nx;
      pc           <= pc_nx;
      saved_target <= saved_target_nx;
      last_off     <= last_off_nx;
      last_pc      <= last_pc_nx;
      inst         <= inst_nx;
      inst_pc      <= inst_pc_nx;
      inst_valid   <= (state_nx == HOLD);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run
// checked against an instruction-stream model of the fetch unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_data;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        branch_taken;
  logic        jump;
  logic        jr;
  logic [31:0] jr_target;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_data(imem_data),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .branch_taken(branch_taken), .jump(jump), .jr(jr), .jr_target(jr_target)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int wait_left = 0;
  bit rand_lat = 0;
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3E1} ^ 32'h1357_9BDF;
  endfunction

  // kind: 0 = jr, 1 = jump, 2 = taken branch; offsets are signed byte offsets
  function automatic logic [31:0] model_target(input int kind, input logic [31:0] pc,
                                               input logic [31:0] word, input logic [31:0] jrt);
    logic [31:0] t;
    logic [31:0] off;
    if (kind == 0) begin
      t = jrt;
    end else if (kind == 1) begin
      off = {6'b0, word[25:0]};
      if (word[25]) off = off - 32'h0400_0000;
      t = pc + 32'd4 + off;
    end else begin
      off = {16'b0, word[15:0]};
      if (word[15]) off = off - 32'h0001_0000;
      t = pc + 32'd4 + off;
    end
    return t - (t % 32'd4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: memory answers from the outputs seen at the negedge, then the
  // edge happens and we return at the following negedge.
  task automatic tick();
    if (reset) begin
      wait_left = 0;
      imem_rdy  = 1'($urandom_range(0, 1));
      imem_data = $urandom;
    end else if (imem_req) begin
      if (wait_left == 0) begin
        imem_rdy  = 1'b1;
        imem_data = memrd(imem_addr);
        wait_left = rand_lat ? int'($urandom_range(0, 3)) : 0;
      end else begin
        imem_rdy  = 1'b0;
        imem_data = $urandom;
        wait_left--;
      end
    end else begin
      imem_rdy  = 1'($urandom_range(0, 1));
      imem_data = $urandom;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] exp_pc, acc_pc, acc_word;
  bit          can_redir, do_redir;
  int          kind, n_acc;

  initial begin
    reset = 1'b1; imem_rdy = 1'b0; imem_data = '0; inst_ready = 1'b0;
    branch_taken = 1'b0; jump = 1'b0; jr = 1'b0; jr_target = '0;
    mem[32'h0]  = 32'h2001_0005;
    mem[32'h4]  = 32'h0022_1820;
    mem[32'h10] = 32'h1020_FFF8;
    mem[32'h40] = 32'h0800_0100;

    // reset state and first fetches with zero-wait memory
    tick(); tick();
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    reset = 1'b0; inst_ready = 1'b1; #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    tick();
    chk("w0_valid", 32'(inst_valid), 32'd1);
    chk("w0_inst", inst, 32'h2001_0005);
    chk("w0_pc", inst_pc, 32'h0);
    tick();
    chk("a4_req", 32'(imem_req), 32'd1);
    chk("a4_addr", imem_addr, 32'h4);
    chk("a4_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("w1_inst", inst, 32'h0022_1820);
    chk("w1_pc", inst_pc, 32'h4);
    tick();
    chk("a8_addr", imem_addr, 32'h8);

    // backpressure
    inst_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(inst_valid), 32'd1);
      chk("bp_pc", inst_pc, 32'h8);
      chk("bp_inst", inst, memrd(32'h8));
      chk("bp_req", 32'(imem_req), 32'd0);
      tick();
    end
    chk("bp_pc_end", inst_pc, 32'h8);
    inst_ready = 1'b1;
    tick();
    chk("bp_next_req", 32'(imem_req), 32'd1);
    chk("bp_next_addr", imem_addr, 32'hC);

    // taken branch while the following word is held
    tick(); tick();
    chk("br_fetch", imem_addr, 32'h10);
    tick();
    chk("br_pc", inst_pc, 32'h10);
    tick(); tick();
    chk("br_held", inst_pc, 32'h14);
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    chk("br_drop", 32'(inst_valid), 32'd0);
    chk("br_req", 32'(imem_req), 32'd1);
    chk("br_addr", imem_addr, 32'hC);

    // jr coinciding with imem_rdy in FETCH, then jump during a stalled fetch
    tick(); tick();
    chk("jr_fetch", imem_addr, 32'h10);
    jr = 1'b1; jr_target = 32'h40;
    tick();
    jr = 1'b0;
    chk("jrf_valid", 32'(inst_valid), 32'd0);
    chk("jrf_addr", imem_addr, 32'h40);
    tick();
    chk("j_inst", inst, 32'h0800_0100);
    chk("j_pc", inst_pc, 32'h40);
    tick();
    chk("j_next", imem_addr, 32'h44);
    wait_left = 3;
    jump = 1'b1;
    tick();
    jump = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drain_req", 32'(imem_req), 32'd1);
      chk("drain_addr", imem_addr, 32'h44);
      chk("drain_valid", 32'(inst_valid), 32'd0);
      if (i < 2) tick();
    end
    tick();
    chk("j_tgt_addr", imem_addr, 32'h144);
    chk("j_tgt_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("j_tgt_pc", inst_pc, 32'h144);

    // jr has priority over jump and branch_taken
    tick();
    chk("pri_fetch", imem_addr, 32'h148);
    tick();
    jr = 1'b1; jump = 1'b1; branch_taken = 1'b1; jr_target = 32'h0000_1003;
    tick();
    jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    chk("pri_addr", imem_addr, 32'h1000);
    chk("pri_valid", 32'(inst_valid), 32'd0);

    // reset with a request pending
    wait_left = 5;
    tick();
    chk("rp_pending", imem_addr, 32'h1000);
    reset = 1'b1; #1;
    chk("rp_req_in_reset", 32'(imem_req), 32'd0);
    tick();
    chk("rp_valid", 32'(inst_valid), 32'd0);
    chk("rp_req", 32'(imem_req), 32'd0);
    reset = 1'b0; #1;
    chk("rp_restart_req", 32'(imem_req), 32'd1);
    chk("rp_restart_addr", imem_addr, 32'h0);
    tick();
    chk("rp_w0_pc", inst_pc, 32'h0);
    chk("rp_w0_inst", inst, 32'h2001_0005);

    // randomized stream: every presented word must be the next one on the
    // architectural path (sequential unless redirected by the last accepted word)
    rand_lat = 1; exp_pc = 32'h0; can_redir = 0; n_acc = 0;
    acc_pc = '0; acc_word = '0;
    for (int c = 0; c < 1000; c++) begin
      if (inst_valid) begin
        chk("rnd_pc", inst_pc, exp_pc);
        chk("rnd_inst", inst, memrd(exp_pc));
      end
      inst_ready = ($urandom_range(0, 2) != 0);
      jr_target  = $urandom;
      do_redir   = can_redir && ($urandom_range(0, 5) == 0);
      if (do_redir) begin
        kind = int'($urandom_range(0, 2));
        jr           = (kind == 0);
        jump         = (kind == 1) || (kind == 0 && $urandom_range(0, 1) == 1);
        branch_taken = (kind == 2) || (kind < 2 && $urandom_range(0, 1) == 1);
        exp_pc = model_target(kind, acc_pc, acc_word, jr_target);
        can_redir = 0;
      end else if (inst_valid && inst_ready) begin
        acc_pc    = exp_pc;
        acc_word  = memrd(exp_pc);
        exp_pc    = exp_pc + 32'd4;
        can_redir = 1;
        n_acc++;
      end
      tick();
      jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    end
    chk("rnd_progress", 32'(n_acc >= 50), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
